// File: rtl/alu_result_fifo_if.sv
// Handshake bundle between the alu producer, alu_result_fifo and the downstream consumer.
// The master modport is the producer/consumer side; the slave modport is the FIFO.
interface alu_result_fifo_if #(
  parameter int DEPTH = 4,
  parameter int OP_W  = 3,
  parameter int RES_W = 5
);
  logic                       in_valid;
  logic                       in_ready;
  logic [OP_W-1:0]            in_op;
  logic [RES_W-1:0]           in_result;
  logic                       out_valid;
  logic                       out_ready;
  logic [OP_W-1:0]            out_op;
  logic [RES_W-1:0]           out_result;
  logic                       out_zero;
  logic                       out_carry;
  logic [$clog2(DEPTH):0]     count;
  logic [7:0]                 accepted;

  modport slave (
    input  in_valid, in_op, in_result, out_ready,
    output in_ready, out_valid, out_op, out_result, out_zero, out_carry, count, accepted
  );

  modport master (
    output in_valid, in_op, in_result, out_ready,
    input  in_ready, out_valid, out_op, out_result, out_zero, out_carry, count, accepted
  );
endinterface

// File: rtl/alu_result_fifo.sv
// In-order buffer of {op, result} pairs with zero/carry decode; 1-cycle push-to-output latency.
// in_ready drops only when DEPTH entries are held (no full bypass); outputs read zero when empty.
module alu_result_fifo #(
  parameter int DEPTH = 4,
  parameter int OP_W  = 3,
  parameter int RES_W = 5
) (
  input logic               clk,
  input logic               rst,
  alu_result_fifo_if.slave  bus
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef struct packed {
    logic [OP_W-1:0]  op;
    logic [RES_W-1:0] res;
  } entry_t;

  entry_t           mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [7:0]       accepted_q, accepted_d;
  logic             full, empty, push, pop;
  entry_t           head;

  assign full  = (count_q == CNT_W'(DEPTH));
  assign empty = (count_q == '0);
  assign push  = bus.in_valid && !full;
  assign pop   = bus.out_ready && !empty;

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    accepted_d = accepted_q;
    if (push) begin
      wr_ptr_d   = wr_ptr_q + PTR_W'(1);
      accepted_d = accepted_q + 8'd1;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      accepted_q <= '0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      accepted_q <= accepted_d;
    end
  end

  // Storage needs no reset: head outputs are masked whenever count is zero.
  always_ff @(posedge clk) begin
    if (push && !rst) begin
      mem_q[wr_ptr_q] <= '{op: bus.in_op, res: bus.in_result};
    end
  end

  assign head = mem_q[rd_ptr_q];

  assign bus.in_ready   = !full;
  assign bus.out_valid  = !empty;
  assign bus.count      = count_q;
  assign bus.accepted   = accepted_q;
  assign bus.out_op     = empty ? '0 : head.op;
  assign bus.out_result = empty ? '0 : head.res;
  assign bus.out_zero   = !empty && (head.res[RES_W-2:0] == '0);
  assign bus.out_carry  = !empty && head.res[RES_W-1];
endmodule
